// File: rtl/gpu_dispatch_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : gpu_dispatch_pkg                                                  |
// | Brief  : shared state encodings and width helpers for the block dispatcher |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package gpu_dispatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  typedef enum logic [1:0] {
    SLOT_FREE  = 2'd0,
    SLOT_BUSY  = 2'd1,
    SLOT_DRAIN = 2'd2
  } slot_state_e;

  // One spare bit so block counters can hold the block total itself.
  function automatic int blk_cnt_w(input int bid_w);
    return bid_w + 1;
  endfunction

  function automatic int thr_cnt_w(input int tpb);
    return $clog2(tpb) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/free_core_picker.sv
// +----------------------------------------------------------------------------+
// | Module : free_core_picker                                                  |
// | Brief  : lowest-index priority encoder over free core slots                |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module free_core_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     free_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] index_o
);

  // Scan from the top so the last hit written is the lowest index.
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_i[i]) begin
        valid_o = 1'b1;
        index_o = IDX_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/block_dispatcher.sv
// +----------------------------------------------------------------------------+
// | Module : block_dispatcher                                                  |
// | Brief  : splits a kernel into blocks and feeds them to recycled cores;     |
// |          optional perf counters behind DISPATCH_PERF_EN                    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module block_dispatcher
  import gpu_dispatch_pkg::*;
#(
  parameter int CORES             = 4,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int TC_W              = 8,
  parameter int BID_W             = 8
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic [TC_W-1:0]                               thread_count,
  input  logic [CORES-1:0]                              core_done,
  output logic [CORES-1:0]                              core_start,
  output logic [CORES-1:0]                              core_reset,
  output logic [CORES*BID_W-1:0]                        core_block_id,
  output logic [CORES*($clog2(THREADS_PER_BLOCK)+1)-1:0] core_thread_count,
  output logic                                          done
`ifdef DISPATCH_PERF_EN
  ,
  output logic [31:0]                                   perf_cycles,
  output logic [$clog2(CORES):0]                        perf_peak_busy
`endif
);

  localparam int TCO_W   = thr_cnt_w(THREADS_PER_BLOCK);
  localparam int CNT_W   = blk_cnt_w(BID_W);
  localparam int LOG_TPB = $clog2(THREADS_PER_BLOCK);
  localparam int IDX_W   = (CORES > 1) ? $clog2(CORES) : 1;
  localparam int PEAK_W  = $clog2(CORES) + 1;
  localparam int TW      = TC_W + 1;
  localparam int RW      = TC_W + BID_W + 2;

  fsm_state_e        state_q, state_d;
  logic [TC_W-1:0]   tc_q, tc_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [CNT_W-1:0]  next_bid_q, next_bid_d;
  logic [CNT_W-1:0]  completed_q, completed_d;
  slot_state_e       slot_q [CORES];
  slot_state_e       slot_d [CORES];
  logic [CORES-1:0]  start_q, start_d;
  logic [CORES-1:0]  rst_q, rst_d;
  logic [BID_W-1:0]  bid_q [CORES];
  logic [BID_W-1:0]  bid_d [CORES];
  logic [TCO_W-1:0]  tcnt_q [CORES];
  logic [TCO_W-1:0]  tcnt_d [CORES];
  logic              done_q, done_d;
  logic [PEAK_W-1:0] n_fin;

  logic [CORES-1:0]  w_free;
  logic              w_pick_valid;
  logic [IDX_W-1:0]  w_pick_idx;
  logic [TW-1:0]     w_total_full;
  logic [RW-1:0]     w_rem;
  logic [TCO_W-1:0]  w_blk_tcnt;

  for (genvar g = 0; g < CORES; g++) begin : g_core
    assign w_free[g]                                = (slot_q[g] == SLOT_FREE);
    assign core_block_id[g*BID_W +: BID_W]          = bid_q[g];
    assign core_thread_count[g*TCO_W +: TCO_W]      = tcnt_q[g];
  end

  free_core_picker #(
    .N     (CORES),
    .IDX_W (IDX_W)
  ) u_picker (
    .free_i  (w_free),
    .valid_o (w_pick_valid),
    .index_o (w_pick_idx)
  );

  assign w_total_full = (TW'(thread_count) + TW'(THREADS_PER_BLOCK - 1)) >> LOG_TPB;
  // Threads left from the next block onward; the last block may be partial.
  assign w_rem        = RW'(tc_q) - (RW'(next_bid_q) << LOG_TPB);
  assign w_blk_tcnt   = (w_rem >= RW'(THREADS_PER_BLOCK)) ? TCO_W'(THREADS_PER_BLOCK)
                                                          : TCO_W'(w_rem);

  always_comb begin
    state_d     = state_q;
    tc_d        = tc_q;
    total_d     = total_q;
    next_bid_d  = next_bid_q;
    slot_d      = slot_q;
    start_d     = start_q;
    rst_d       = rst_q;
    bid_d       = bid_q;
    tcnt_d      = tcnt_q;
    n_fin       = '0;

    for (int i = 0; i < CORES; i++) begin
      if (slot_q[i] == SLOT_BUSY && core_done[i]) begin
        slot_d[i]  = SLOT_DRAIN;
        start_d[i] = 1'b0;
        rst_d[i]   = 1'b1;
        n_fin      = n_fin + PEAK_W'(1);
      end else if (slot_q[i] == SLOT_DRAIN) begin
        slot_d[i]  = SLOT_FREE;
        rst_d[i]   = 1'b0;
      end
    end
    completed_d = completed_q + CNT_W'(n_fin);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          tc_d        = thread_count;
          total_d     = CNT_W'(w_total_full);
          next_bid_d  = '0;
          completed_d = '0;
          state_d     = (thread_count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (completed_q == total_q) begin
          state_d = ST_DONE;
        end else if (next_bid_q < total_q && w_pick_valid) begin
          slot_d[w_pick_idx]  = SLOT_BUSY;
          start_d[w_pick_idx] = 1'b1;
          bid_d[w_pick_idx]   = BID_W'(next_bid_q);
          tcnt_d[w_pick_idx]  = w_blk_tcnt;
          next_bid_d          = next_bid_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tc_q        <= '0;
      total_q     <= '0;
      next_bid_q  <= '0;
      completed_q <= '0;
      start_q     <= '0;
      rst_q       <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < CORES; i++) begin
        slot_q[i] <= SLOT_FREE;
        bid_q[i]  <= '0;
        tcnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      tc_q        <= tc_d;
      total_q     <= total_d;
      next_bid_q  <= next_bid_d;
      completed_q <= completed_d;
      start_q     <= start_d;
      rst_q       <= rst_d;
      done_q      <= done_d;
      slot_q      <= slot_d;
      bid_q       <= bid_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign core_start = start_q;
  assign core_reset = rst_q;
  assign done       = done_q;

`ifdef DISPATCH_PERF_EN
  logic [31:0]       perf_cycles_q;
  logic [PEAK_W-1:0] peak_q;
  logic [PEAK_W-1:0] w_busy_cnt;
  logic              w_accept;

  assign w_accept = start && (state_q != ST_RUN);

  always_comb begin
    w_busy_cnt = '0;
    for (int i = 0; i < CORES; i++) begin
      if (slot_q[i] == SLOT_BUSY) w_busy_cnt = w_busy_cnt + PEAK_W'(1);
    end
  end

  // Only RUN cycles advance the counters, so both freeze once done is up.
  always_ff @(posedge clk) begin
    if (reset || w_accept) begin
      perf_cycles_q <= '0;
      peak_q        <= '0;
    end else if (state_q == ST_RUN) begin
      if (perf_cycles_q != '1) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (w_busy_cnt > peak_q) peak_q <= w_busy_cnt;
    end
  end

  assign perf_cycles    = perf_cycles_q;
  assign perf_peak_busy = peak_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_block_dispatcher.sv
// +----------------------------------------------------------------------------+
// | Module : tb_block_dispatcher                                               |
// | Brief  : randomized kernel launches checked against a behavioural model    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_block_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  thread_count;
  logic [3:0]  core_done;
  logic [3:0]  core_start;
  logic [3:0]  core_reset;
  logic [31:0] core_block_id;
  logic [11:0] core_thread_count;
  logic        done;

  always #5 clk = ~clk;

  block_dispatcher #(
    .CORES             (4),
    .THREADS_PER_BLOCK (4),
    .TC_W              (8),
    .BID_W             (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .thread_count      (thread_count),
    .core_done         (core_done),
    .core_start        (core_start),
    .core_reset        (core_reset),
    .core_block_id     (core_block_id),
    .core_thread_count (core_thread_count),
    .done              (done)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Expected visible outputs for the current cycle; a core is busy while its
  // start is high, draining while its reset pulse is high, free otherwise.
  bit [3:0] e_start, e_rst;
  bit [7:0] e_bid  [4];
  bit [2:0] e_tcnt [4];
  bit       e_done;
  int       k_active, k_tc, k_total, k_next, k_comp;
  int       lat [4];
  int       lat_min, lat_max;
  bit       glitch;

  int       cyc, last_rst_cyc, done_rise_cyc;
  bit [3:0] prev_cs;
  bit       prev_done;
  int       lg_core[$], lg_bid[$], lg_tcnt[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cycle();
    bit [3:0] ns, nr;
    bit [7:0] nb [4];
    bit [2:0] nt [4];
    bit       nd;
    int       nc, f, left;
    for (int i = 0; i < 4; i++) begin
      if (e_start[i]) begin
        if (lat[i] == 0) core_done[i] = 1'b1;
        else begin core_done[i] = 1'b0; lat[i]--; end
      end else begin
        core_done[i] = glitch && ($urandom % 4 == 0);
      end
    end
    ns = e_start; nr = e_rst; nb = e_bid; nt = e_tcnt; nd = e_done;
    if (reset) begin
      ns = '0; nr = '0; nd = 1'b0;
      for (int i = 0; i < 4; i++) begin nb[i] = '0; nt[i] = '0; end
      k_active = 0; k_tc = 0; k_total = 0; k_next = 0; k_comp = 0;
    end else begin
      nc = 0;
      for (int i = 0; i < 4; i++) begin
        if (e_start[i] && core_done[i]) begin ns[i] = 0; nr[i] = 1; nc++; end
        else if (e_rst[i]) nr[i] = 0;
      end
      if (!k_active && start) begin
        k_tc = int'(thread_count); k_total = (k_tc + 3) / 4;
        k_next = 0; k_comp = 0;
        k_active = (k_tc != 0);
        nd = (k_tc == 0);
      end else if (k_active) begin
        if (k_comp == k_total) begin
          k_active = 0; nd = 1'b1;
        end else begin
          if (k_next < k_total) begin
            f = -1;
            for (int i = 3; i >= 0; i--) if (!e_start[i] && !e_rst[i]) f = i;
            if (f >= 0) begin
              left = k_tc - 4 * k_next;
              ns[f] = 1'b1; nb[f] = 8'(k_next); nt[f] = 3'((left > 4) ? 4 : left);
              lat[f] = $urandom_range(lat_max, lat_min);
              k_next++;
            end
          end
          k_comp += nc;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e_start = ns; e_rst = nr; e_bid = nb; e_tcnt = nt; e_done = nd;
    chk("done", done, e_done);
    chk("core_start", core_start, e_start);
    chk("core_reset", core_reset, e_rst);
    chk("core_block_id", core_block_id, {e_bid[3], e_bid[2], e_bid[1], e_bid[0]});
    chk("core_thread_count", core_thread_count, {e_tcnt[3], e_tcnt[2], e_tcnt[1], e_tcnt[0]});
    for (int i = 0; i < 4; i++) begin
      if (core_start[i] && !prev_cs[i]) begin
        lg_core.push_back(i);
        lg_bid.push_back(int'(core_block_id[i*8 +: 8]));
        lg_tcnt.push_back(int'(core_thread_count[i*3 +: 3]));
      end
    end
    if (core_reset != 4'h0) last_rst_cyc = cyc;
    if (done && !prev_done) done_rise_cyc = cyc;
    prev_cs   = core_start;
    prev_done = done;
  endtask

  task automatic run_kernel(input int tc, input int lmin, input int lmax, input bit noise);
    lg_core.delete(); lg_bid.delete(); lg_tcnt.delete();
    lat_min = lmin; lat_max = lmax;
    start = 1'b1; thread_count = 8'(tc);
    cycle();
    start = 1'b0;
    for (int n = 0; n < 3000 && !e_done; n++) begin
      if (noise) begin
        start        = ($urandom % 6 == 0);
        thread_count = 8'($urandom);
      end
      cycle();
    end
    start = 1'b0;
    if (!e_done) begin
      total_cnt++; bad_cnt++;
      $display("FAIL kernel_timeout: done=%0b want 1 (tc %0d)", done, tc);
    end
    cycle();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; thread_count = '0; core_done = '0; glitch = 1'b0;
    e_start = '0; e_rst = '0; e_done = 1'b0;
    for (int i = 0; i < 4; i++) begin e_bid[i] = '0; e_tcnt[i] = '0; lat[i] = 0; end
    k_active = 0; k_tc = 0; k_total = 0; k_next = 0; k_comp = 0;
    lat_min = 1; lat_max = 1; cyc = 0; prev_cs = '0; prev_done = 1'b0;
    last_rst_cyc = 0; done_rise_cyc = 0;
    cycle(); cycle();
    chk("reset_done", done, 1'b0);
    chk("reset_core_start", core_start, 4'h0);
    chk("reset_block_id", core_block_id, 32'h0);
    reset = 1'b0;
    cycle();

    // Exactly one full round: blocks 0..3 land on cores 0..3.
    run_kernel(16, 5, 5, 1'b0);
    chk("t16_dispatches", lg_core.size(), 4);
    for (int j = 0; j < 4; j++) begin
      chk("t16_core", lg_core[j], j);
      chk("t16_bid", lg_bid[j], j);
      chk("t16_tcnt", lg_tcnt[j], 4);
    end
    chk("t16_done_latency", done_rise_cyc - last_rst_cyc, 1);

    // Partial last block, unused core 3.
    run_kernel(10, 3, 3, 1'b0);
    chk("t10_dispatches", lg_core.size(), 3);
    chk("t10_last_core", lg_core[2], 2);
    chk("t10_last_bid", lg_bid[2], 2);
    chk("t10_last_tcnt", lg_tcnt[2], 2);

    // More blocks than cores with staggered finish times.
    run_kernel(40, 2, 9, 1'b0);
    chk("t40_dispatches", lg_core.size(), 10);
    for (int j = 0; j < 10; j++) chk("t40_bid_order", lg_bid[j], j);
    chk("t40_done_latency", done_rise_cyc - last_rst_cyc, 1);

    // Zero-thread kernel completes without touching any core.
    start = 1'b1; thread_count = 8'd0;
    cycle();
    start = 1'b0;
    chk("t0_done", done, 1'b1);
    chk("t0_core_start", core_start, 4'h0);
    cycle();
    chk("t0_done_held", done, 1'b1);

    // Reset while three cores are busy, then a single-block kernel.
    lat_min = 20; lat_max = 20;
    start = 1'b1; thread_count = 8'd40;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    chk("pre_reset_busy", core_start, 4'b0111);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("mid_reset_start", core_start, 4'h0);
    chk("mid_reset_rst", core_reset, 4'h0);
    chk("mid_reset_bid", core_block_id, 32'h0);
    chk("mid_reset_tcnt", core_thread_count, 12'h0);
    run_kernel(4, 3, 3, 1'b0);
    chk("t4_dispatches", lg_core.size(), 1);
    chk("t4_core", lg_core[0], 0);
    chk("t4_bid", lg_bid[0], 0);
    chk("t4_tcnt", lg_tcnt[0], 4);

    // Random kernels with ignored starts, thread_count noise and stray done pulses.
    glitch = 1'b1;
    for (int k = 0; k < 40; k++) begin
      run_kernel(int'($urandom_range(255, 0)), 0, 8, 1'b1);
    end
    glitch = 1'b0;
    run_kernel(255, 1, 4, 1'b0);
    chk("t255_dispatches", lg_core.size(), 64);
    chk("t255_last_tcnt", lg_tcnt[63], 3);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

`default_nettype wire
